cr16_controller: RTL and testbench

- Multi-cycle control FSM that sequences the 16-bit datapath through the fetch, decode and execute phases.
- Holds the instruction register (IR) and the processor status flags (PSR).
- Drives every datapath mux select, write enable and register address.
- Forwards the opcode and opext fields to alucontrol; sits between the datapath, alucontrol and unified instruction/data memory.

---
 rtl/cr16_pkg.sv | 89 ++++++++
 rtl/cr16_cond_eval.sv | 33 +++
 rtl/cr16_controller.sv | 193 +++++++++++++++++++
 tb/tb_cr16_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// cr16_pkg: shared types and constants for the CR16 multi-cycle controller.
// Controller state encoding, opcode/opext fields, datapath mux select
// encodings, branch condition codes and PSR bit positions.
package cr16_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_IRLD,
        S_DECODE,
        S_RTYPE,
        S_ITYPE,
        S_LDA,
        S_LWB,
        S_STR,
        S_BCND,
        S_JCND,
        S_JAL
    } state_t;

    // Primary opcode field IR[15:12]; for RTYPE the same codes live in IR[7:4]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_LDST  = 4'b0100;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_BCND  = 4'b1100;
    localparam logic [3:0] OP_MOV   = 4'b1101;

    // Secondary field IR[7:4] under OP_LDST
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;
    localparam logic [3:0] EXT_JAL  = 4'b1000;
    localparam logic [3:0] EXT_JCND = 4'b1100;
    localparam logic [3:0] EXT_NONE = 4'b0000;

    // Datapath mux select encodings
    localparam logic       MEM_S_PC   = 1'b0;
    localparam logic       MEM_S_RSRC = 1'b1;
    localparam logic       PC_S_ALU   = 1'b0;
    localparam logic       PC_S_RSRC  = 1'b1;
    localparam logic [1:0] ALUA_PC    = 2'b00;
    localparam logic [1:0] ALUA_RDEST = 2'b01;
    localparam logic [1:0] ALUA_ZERO  = 2'b10;
    localparam logic       ALUB_RSRC  = 1'b0;
    localparam logic       ALUB_IMM   = 1'b1;
    localparam logic [1:0] WD_MEM     = 2'b01;
    localparam logic [1:0] WD_PC      = 2'b10;
    localparam logic [1:0] WD_ALU     = 2'b11;
    localparam logic       WA_RDEST   = 1'b1;

    // Condition codes IR[11:8] for Bcond / Jcond
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    // PSR / alu_flags bit positions: {C,L,F,Z,N}
    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    // Arithmetic ops are the only ones that update the PSR
    function automatic logic sets_flags(input logic [3:0] fn);
        return (fn == OP_ADD) || (fn == OP_SUB) || (fn == OP_CMP);
    endfunction

    // Logic immediates are zero-extended rather than sign-extended
    function automatic logic is_logic_op(input logic [3:0] fn);
        return (fn == OP_AND) || (fn == OP_OR) || (fn == OP_XOR);
    endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// cr16_cond_eval: combinational branch/jump condition evaluation against PSR.
module cr16_cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       take
);

    // Decode the 4-bit condition code into a taken flag
    always_comb begin
        take = 1'b0;
        case (cond)
            CC_EQ: take =  psr[PSR_Z];
            CC_NE: take = ~psr[PSR_Z];
            CC_CS: take =  psr[PSR_C];
            CC_CC: take = ~psr[PSR_C];
            CC_HI: take =  psr[PSR_L];
            CC_LS: take = ~psr[PSR_L];
            CC_GT: take =  psr[PSR_N];
            CC_LE: take = ~psr[PSR_N];
            CC_FS: take =  psr[PSR_F];
            CC_FC: take = ~psr[PSR_F];
            CC_LO: take = ~psr[PSR_L] & ~psr[PSR_Z];
            CC_HS: take =  psr[PSR_L] |  psr[PSR_Z];
            CC_LT: take = ~psr[PSR_N] & ~psr[PSR_Z];
            CC_GE: take =  psr[PSR_N] |  psr[PSR_Z];
            CC_UC: take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_controller.sv
// cr16_controller: multi-cycle fetch/decode/execute control FSM for the
// 16-bit CR16 datapath. Owns IR and PSR and drives all datapath selects.
// Optional macro CTRL_MEMWAIT_EN adds a mem_ready handshake that stalls
// FETCH, LDA and STR until memory responds.
module cr16_controller
    import cr16_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter int IMM     = 8
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CTRL_MEMWAIT_EN
    input  logic               mem_ready,
`endif
    input  logic [WIDTH-1:0]   mem_out,
    input  logic [4:0]         alu_flags,
    output logic               wa_s,
    output logic               pc_s,
    output logic               alub_s,
    output logic               mem_s,
    output logic [1:0]         wd_s,
    output logic [1:0]         alua_s,
    output logic               pcen,
    output logic               regwrite,
    output logic               mem_we,
    output logic               signext_sign,
    output logic [REGBITS-1:0] rsrc_addr,
    output logic [REGBITS-1:0] rdest_addr,
    output logic [IMM-1:0]     imm,
    output logic [3:0]         opcode,
    output logic [3:0]         opext,
    output logic [4:0]         psr
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [4:0]       psr_q, psr_d;
    logic             take;
    logic             mem_rdy;
    logic [3:0]       ir_op, ir_ext, alu_fn;

`ifdef CTRL_MEMWAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign ir_op      = ir_q[15:12];
    assign ir_ext     = ir_q[7:4];
    // RTYPE carries its ALU function in opext, ITYPE in the opcode itself
    assign alu_fn     = (state_q == S_RTYPE) ? ir_ext : ir_op;
    assign rsrc_addr  = ir_q[REGBITS-1:0];
    assign rdest_addr = ir_q[8 +: REGBITS];
    assign psr        = psr_q;

    cr16_cond_eval u_cond (
        .cond (ir_q[11:8]),
        .psr  (psr_q),
        .take (take)
    );

    // State, instruction and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            psr_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            psr_q   <= psr_d;
        end
    end

    // Next-state, register updates and datapath controls per phase
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        psr_d        = psr_q;
        pcen         = 1'b0;
        regwrite     = 1'b0;
        mem_we       = 1'b0;
        mem_s        = MEM_S_PC;
        pc_s         = PC_S_ALU;
        wa_s         = WA_RDEST;
        wd_s         = WD_ALU;
        alua_s       = ALUA_RDEST;
        alub_s       = ALUB_RSRC;
        signext_sign = 1'b1;
        imm          = ir_q[IMM-1:0];
        opcode       = ir_op;
        opext        = ir_ext;

        case (state_q)
            S_FETCH: begin
                // PC <= PC + 1 while memory reads the instruction at PC
                mem_s   = MEM_S_PC;
                alua_s  = ALUA_PC;
                alub_s  = ALUB_IMM;
                imm     = IMM'(1);
                opcode  = OP_ADD;
                opext   = EXT_NONE;
                pcen    = mem_rdy;
                if (mem_rdy) state_d = S_IRLD;
            end
            S_IRLD: begin
                ir_d    = mem_out;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_op)
                    OP_RTYPE: state_d = S_RTYPE;
                    OP_AND, OP_OR, OP_XOR, OP_ADD,
                    OP_SUB, OP_CMP, OP_MOV: state_d = S_ITYPE;
                    OP_LDST: begin
                        case (ir_ext)
                            EXT_LOAD: state_d = S_LDA;
                            EXT_STOR: state_d = S_STR;
                            EXT_JCND: state_d = S_JCND;
                            EXT_JAL:  state_d = S_JAL;
                            default:  state_d = S_FETCH;
                        endcase
                    end
                    OP_BCND: state_d = S_BCND;
                    default: state_d = S_FETCH;
                endcase
            end
            S_RTYPE, S_ITYPE: begin
                alub_s   = (state_q == S_ITYPE) ? ALUB_IMM : ALUB_RSRC;
                if (state_q == S_ITYPE && is_logic_op(alu_fn))
                    signext_sign = 1'b0;
                if (alu_fn == OP_MOV)
                    alua_s = ALUA_ZERO;
                regwrite = (alu_fn != OP_CMP);
                if (sets_flags(alu_fn))
                    psr_d = alu_flags;
                state_d  = S_FETCH;
            end
            S_LDA: begin
                mem_s = MEM_S_RSRC;
                if (mem_rdy) state_d = S_LWB;
            end
            S_LWB: begin
                wd_s     = WD_MEM;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_STR: begin
                // mem_we stays up for as long as memory is stalling the write
                mem_s  = MEM_S_RSRC;
                mem_we = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_BCND: begin
                // PC already holds PC+1 from FETCH; add the signed displacement
                if (take) begin
                    alua_s = ALUA_PC;
                    alub_s = ALUB_IMM;
                    opcode = OP_ADD;
                    opext  = EXT_NONE;
                    pcen   = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_JCND: begin
                if (take) begin
                    pc_s = PC_S_RSRC;
                    pcen = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_JAL: begin
                // Link and jump together: regfile writes the pre-update PC
                wd_s     = WD_PC;
                regwrite = 1'b1;
                pc_s     = PC_S_RSRC;
                pcen     = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // No datapath side effects while reset is held
        if (reset) begin
            pcen     = 1'b0;
            regwrite = 1'b0;
            mem_we   = 1'b0;
        end
    end

endmodule

// File: tb/tb_cr16_controller.sv
// tb_cr16_controller: directed, table-driven check of the CR16 controller.
// Each vector runs one instruction through FETCH/IRLD/DECODE/execute and
// compares the control word, ALU op fields, immediate, addresses and PSR.
module tb_cr16_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ready;
    logic [15:0] mem_out;
    logic [4:0]  alu_flags;
    logic        wa_s, pc_s, alub_s, mem_s, pcen, regwrite, mem_we, signext_sign;
    logic [1:0]  wd_s, alua_s;
    logic [3:0]  rsrc_addr, rdest_addr, opcode, opext;
    logic [7:0]  imm;
    logic [4:0]  psr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cr16_controller dut (
        .clk          (clk),
        .reset        (reset),
`ifdef CTRL_MEMWAIT_EN
        .mem_ready    (mem_ready),
`endif
        .mem_out      (mem_out),
        .alu_flags    (alu_flags),
        .wa_s         (wa_s),
        .pc_s         (pc_s),
        .alub_s       (alub_s),
        .mem_s        (mem_s),
        .wd_s         (wd_s),
        .alua_s       (alua_s),
        .pcen         (pcen),
        .regwrite     (regwrite),
        .mem_we       (mem_we),
        .signext_sign (signext_sign),
        .rsrc_addr    (rsrc_addr),
        .rdest_addr   (rdest_addr),
        .imm          (imm),
        .opcode       (opcode),
        .opext        (opext),
        .psr          (psr)
    );

    // Control word: {pcen,regwrite,mem_we,pc_s,mem_s,wa_s,wd_s,alua_s,alub_s,signext_sign}
    logic [11:0] ctl;
    assign ctl = {pcen, regwrite, mem_we, pc_s, mem_s, wa_s, wd_s, alua_s, alub_s, signext_sign};

    localparam logic [11:0] C_FETCH = 12'b1_0_0_0_0_1_11_00_1_1;
    localparam logic [11:0] C_RSTF  = 12'b0_0_0_0_0_1_11_00_1_1;
    localparam logic [11:0] C_IDLE  = 12'b0_0_0_0_0_1_11_01_0_1;
    localparam logic [11:0] C_ALUR  = 12'b0_1_0_0_0_1_11_01_0_1;
    localparam logic [11:0] C_MOVR  = 12'b0_1_0_0_0_1_11_10_0_1;
    localparam logic [11:0] C_MOVI  = 12'b0_1_0_0_0_1_11_10_1_1;
    localparam logic [11:0] C_ALUI  = 12'b0_1_0_0_0_1_11_01_1_1;
    localparam logic [11:0] C_LOGI  = 12'b0_1_0_0_0_1_11_01_1_0;
    localparam logic [11:0] C_CMPI  = 12'b0_0_0_0_0_1_11_01_1_1;
    localparam logic [11:0] C_BTAK  = 12'b1_0_0_0_0_1_11_00_1_1;
    localparam logic [11:0] C_LDA   = 12'b0_0_0_0_1_1_11_01_0_1;
    localparam logic [11:0] C_LWB   = 12'b0_1_0_0_0_1_01_01_0_1;
    localparam logic [11:0] C_STR   = 12'b0_0_1_0_1_1_11_01_0_1;
    localparam logic [11:0] C_JAL   = 12'b1_1_0_1_0_1_10_01_0_1;
    localparam logic [11:0] C_JTAK  = 12'b1_0_0_1_0_1_11_01_0_1;

    typedef struct {
        logic [15:0] ir;
        logic [4:0]  flags;
        logic [11:0] ctl;
        logic [3:0]  op;
        logic [3:0]  ext;
        logic [4:0]  psr;
        int          cyc;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // PSR values track the expected result of each prior vector
        tv.push_back('{16'h0251, 5'b10001, C_ALUR, 4'h0, 4'h5, 5'b10001, 4}); // ADD R2,R1
        tv.push_back('{16'h0314, 5'b00010, C_ALUR, 4'h0, 4'h1, 5'b10001, 4}); // AND
        tv.push_back('{16'h05D6, 5'b00110, C_MOVR, 4'h0, 4'hD, 5'b10001, 4}); // MOV
        tv.push_back('{16'hB207, 5'b00010, C_CMPI, 4'hB, 4'h0, 5'b00010, 4}); // CMPI R2,#7
        tv.push_back('{16'hC0FD, 5'b11111, C_BTAK, 4'h5, 4'h0, 5'b00010, 4}); // BEQ -3 taken
        tv.push_back('{16'hC1FD, 5'b11111, C_IDLE, 4'hC, 4'hF, 5'b00010, 4}); // BNE not taken
        tv.push_back('{16'h1180, 5'b11111, C_LOGI, 4'h1, 4'h8, 5'b00010, 4}); // ANDI zext
        tv.push_back('{16'h51FF, 5'b11000, C_ALUI, 4'h5, 4'hF, 5'b11000, 4}); // ADDI -1
        tv.push_back('{16'h4304, 5'b00000, C_LDA,  4'h4, 4'h0, 5'b11000, 5}); // LOAD R3,[R4]
        tv.push_back('{16'h4344, 5'b00000, C_STR,  4'h4, 4'h4, 5'b11000, 4}); // STOR
        tv.push_back('{16'h4586, 5'b00000, C_JAL,  4'h4, 4'h8, 5'b11000, 4}); // JAL R5,R6
        tv.push_back('{16'h42C7, 5'b00000, C_JTAK, 4'h4, 4'hC, 5'b11000, 4}); // JCS taken
        tv.push_back('{16'h4AC7, 5'b00000, C_IDLE, 4'h4, 4'hC, 5'b11000, 4}); // JLO not taken
        tv.push_back('{16'hCEFD, 5'b00000, C_BTAK, 4'h5, 4'h0, 5'b11000, 4}); // BUC
        tv.push_back('{16'hCF05, 5'b00000, C_IDLE, 4'hC, 4'h0, 5'b11000, 4}); // never
        tv.push_back('{16'h6000, 5'b11111, C_IDLE, 4'h6, 4'h0, 5'b11000, 3}); // NOP opcode
        tv.push_back('{16'h40F0, 5'b11111, C_IDLE, 4'h4, 4'hF, 5'b11000, 3}); // NOP opext
        tv.push_back('{16'h0192, 5'b00001, C_ALUR, 4'h0, 4'h9, 5'b00001, 4}); // SUB
        tv.push_back('{16'hC6FD, 5'b00000, C_BTAK, 4'h5, 4'h0, 5'b00001, 4}); // BGT taken
        tv.push_back('{16'hC7FD, 5'b00000, C_IDLE, 4'hC, 4'hF, 5'b00001, 4}); // BLE
        tv.push_back('{16'hCBFD, 5'b00000, C_IDLE, 4'hC, 4'hF, 5'b00001, 4}); // BHS
        tv.push_back('{16'hCCFD, 5'b00000, C_IDLE, 4'hC, 4'hF, 5'b00001, 4}); // BLT
        tv.push_back('{16'h3C0F, 5'b11111, C_LOGI, 4'h3, 4'h0, 5'b00001, 4}); // XORI
        tv.push_back('{16'h2A55, 5'b11111, C_LOGI, 4'h2, 4'h5, 5'b00001, 4}); // ORI
        tv.push_back('{16'h02B1, 5'b01000, C_IDLE, 4'h0, 4'hB, 5'b01000, 4}); // CMP R2,R1
        tv.push_back('{16'hC4FD, 5'b00000, C_BTAK, 4'h5, 4'h0, 5'b01000, 4}); // BHI taken
        tv.push_back('{16'hD3AA, 5'b11111, C_MOVI, 4'hD, 4'hA, 5'b01000, 4}); // MOVI

        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_out   = 16'h0000;
        alu_flags = 5'b00000;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'(ctl), 32'(C_RSTF));
        chk("reset_psr", 32'(psr), 32'd0);
        chk("reset_ir",  32'({rdest_addr, rsrc_addr}), 32'd0);
        reset = 1'b0;
        #1;

        // Each iteration starts on the negedge inside FETCH
        for (int i = 0; i < tv.size(); i++) begin
            mem_out   = tv[i].ir;
            alu_flags = tv[i].flags;
            chk($sformatf("v%0d_fetch_ctl", i), 32'(ctl), 32'(C_FETCH));
            chk($sformatf("v%0d_fetch_op", i), 32'({opcode, opext, imm}), 32'h50_01);
            @(negedge clk);
            chk($sformatf("v%0d_irld_ctl", i), 32'(ctl), 32'(C_IDLE));
            @(negedge clk);
            chk($sformatf("v%0d_dec_ctl", i), 32'(ctl), 32'(C_IDLE));
            if (tv[i].cyc >= 4) begin
                @(negedge clk);
                chk($sformatf("v%0d_exec_ctl", i), 32'(ctl), 32'(tv[i].ctl));
                chk($sformatf("v%0d_exec_op", i), 32'({opcode, opext}), 32'({tv[i].op, tv[i].ext}));
                chk($sformatf("v%0d_exec_fields", i), 32'({rdest_addr, rsrc_addr, imm}),
                    32'({tv[i].ir[11:8], tv[i].ir[3:0], tv[i].ir[7:0]}));
            end
            if (tv[i].cyc == 5) begin
                @(negedge clk);
                chk($sformatf("v%0d_lwb_ctl", i), 32'(ctl), 32'(C_LWB));
            end
            @(negedge clk);
            chk($sformatf("v%0d_psr", i), 32'(psr), 32'(tv[i].psr));
        end

`ifdef CTRL_MEMWAIT_EN
        // Store stalled by memory: mem_we held, PC frozen, then released
        begin
            int we_cycles = 0;
            mem_out = 16'h4344;
            chk("mw_fetch_ctl", 32'(ctl), 32'(C_FETCH));
            @(negedge clk);
            @(negedge clk);
            mem_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (mem_we) we_cycles++;
                chk($sformatf("mw_str_pcen%0d", k), 32'(pcen), 32'd0);
                if (k == 3) mem_ready = 1'b1;
            end
            chk("mw_we_cycles", 32'(we_cycles), 32'd4);
            @(negedge clk);
            chk("mw_after_ctl", 32'(ctl), 32'(C_FETCH));
            // FETCH stall: no PC increment until memory is ready
            mem_ready = 1'b0;
            #1;
            chk("mw_fetch_hold", 32'(pcen), 32'd0);
            @(negedge clk);
            chk("mw_fetch_hold2", 32'(ctl), 32'(C_RSTF));
            mem_ready = 1'b1;
            #1;
            chk("mw_fetch_go", 32'(pcen), 32'd1);
            mem_out = 16'h6000;
            @(negedge clk);
            chk("mw_irld", 32'(ctl), 32'(C_IDLE));
            @(negedge clk);
            @(negedge clk);
        end
`endif

        // Reset mid-LDA abandons the load: no LWB write, PSR cleared
        mem_out = 16'h4304;
        chk("rst_pre_psr", 32'(psr), 32'(5'b01000));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_lda", 32'(ctl), 32'(C_LDA));
        reset = 1'b1;
        #1;
        chk("rst_async_en", 32'({pcen, regwrite, mem_we}), 32'd0);
        chk("rst_async_psr", 32'(psr), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        mem_out = 16'h0000;
        #1;
        chk("rst_back_fetch", 32'(ctl), 32'(C_FETCH));
        chk("rst_ir_clear", 32'({rdest_addr, rsrc_addr}), 32'd0);
        @(negedge clk);
        chk("rst_no_lwb", 32'(ctl), 32'(C_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
